// File: rtl/self_attention_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : self_attention_ctrl
// Brief    : Tile sequencer for one self-attention head pass. Clears and feeds
//            the matmul array, waits for its results, then launches B2R.
// Revision : 1.0  initial release
// ============================================================================
module self_attention_ctrl #(
    parameter int INNER_STEPS = 4,
    parameter int NUM_TILES   = 8,
    parameter int TIMEOUT     = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         in_data_valid,
    input  logic                         acc_done,
    input  logic                         sys_finish,
    input  logic                         shift_out_valid,
    input  logic                         b2r_ready,
    input  logic                         b2r_done,
    output logic                         mm_rst_n,
    output logic                         mm_en,
    output logic                         mm_reset_acc,
    output logic                         in_data_rd,
    output logic                         b2r_start,
    output logic [$clog2(NUM_TILES)-1:0] tile_idx,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int BEAT_W = $clog2(INNER_STEPS + 1);
    localparam int WDOG_W = $clog2(TIMEOUT + 1);
    localparam int TILE_W = $clog2(NUM_TILES);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_CLR        = 4'd1,
        S_FEED       = 4'd2,
        S_WAIT_RES   = 4'd3,
        S_WAIT_SHIFT = 4'd4,
        S_B2R_REQ    = 4'd5,
        S_B2R_WAIT   = 4'd6,
        S_NEXT       = 4'd7,
        S_ERR        = 4'd8
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [BEAT_W-1:0]   r_beatCnt;
    logic [WDOG_W-1:0]   r_wdog;
    logic [TILE_W-1:0]   r_tileIdx;
    logic                r_accSeen;
    logic                r_sysSeen;
    logic                r_shiftSeen;

    logic w_accAny;
    logic w_sysAny;
    logic w_shiftAny;
    logic w_lastBeat;
    logic w_lastTile;
    logic w_waitState;
    logic w_timeout;

    // Events landing in the current cycle count as seen, so a same-cycle pulse is never lost.
    assign w_accAny    = r_accSeen   | acc_done;
    assign w_sysAny    = r_sysSeen   | sys_finish;
    assign w_shiftAny  = r_shiftSeen | shift_out_valid;
    assign w_lastBeat  = (r_beatCnt == BEAT_W'(INNER_STEPS - 1));
    assign w_lastTile  = (r_tileIdx == TILE_W'(NUM_TILES - 1));
    assign w_waitState = (r_state == S_WAIT_RES) || (r_state == S_WAIT_SHIFT) ||
                         (r_state == S_B2R_WAIT);
    assign w_timeout   = w_waitState && (r_wdog == WDOG_W'(TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (start) w_next = S_CLR;
            S_CLR:        w_next = S_FEED;
            S_FEED:       if (in_data_valid && w_lastBeat) w_next = S_WAIT_RES;
            S_WAIT_RES: begin
                if (w_accAny && w_sysAny) w_next = S_WAIT_SHIFT;
                else if (w_timeout)       w_next = S_ERR;
            end
            S_WAIT_SHIFT: begin
                if (w_shiftAny)     w_next = S_B2R_REQ;
                else if (w_timeout) w_next = S_ERR;
            end
            S_B2R_REQ:    if (b2r_ready) w_next = S_B2R_WAIT;
            S_B2R_WAIT: begin
                if (b2r_done)       w_next = S_NEXT;
                else if (w_timeout) w_next = S_ERR;
            end
            S_NEXT:       w_next = w_lastTile ? S_IDLE : S_CLR;
            S_ERR:        w_next = S_ERR;
            default:      w_next = S_IDLE;
        endcase
        if (abort) w_next = S_IDLE;
    end

    always_comb begin
        mm_rst_n     = 1'b1;
        mm_en        = 1'b0;
        mm_reset_acc = 1'b0;
        in_data_rd   = 1'b0;
        b2r_start    = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        busy         = (r_state != S_IDLE) && (r_state != S_ERR);
        tile_idx     = r_tileIdx;
        case (r_state)
            S_CLR: begin
                mm_rst_n     = 1'b0;
                mm_reset_acc = 1'b1;
            end
            S_FEED: begin
                mm_en      = in_data_valid;
                in_data_rd = in_data_valid;
            end
            S_WAIT_RES: mm_en     = 1'b1;
            S_B2R_REQ:  b2r_start = b2r_ready && !abort;
            S_NEXT:     done      = w_lastTile && !abort;
            S_ERR: begin
                mm_rst_n = 1'b0;
                err      = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            mm_rst_n     = 1'b0;
            mm_en        = 1'b0;
            mm_reset_acc = 1'b0;
            in_data_rd   = 1'b0;
            b2r_start    = 1'b0;
            done         = 1'b0;
            err          = 1'b0;
            busy         = 1'b0;
            tile_idx     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_beatCnt   <= '0;
            r_wdog      <= '0;
            r_tileIdx   <= '0;
            r_accSeen   <= 1'b0;
            r_sysSeen   <= 1'b0;
            r_shiftSeen <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_next != r_state)
                r_wdog <= '0;
            else if (w_waitState)
                r_wdog <= r_wdog + WDOG_W'(1);

            case (r_state)
                S_IDLE, S_CLR: begin
                    r_beatCnt   <= '0;
                    r_accSeen   <= 1'b0;
                    r_sysSeen   <= 1'b0;
                    r_shiftSeen <= 1'b0;
                end
                S_FEED, S_WAIT_RES, S_WAIT_SHIFT: begin
                    if (r_state == S_FEED && in_data_valid)
                        r_beatCnt <= r_beatCnt + BEAT_W'(1);
                    if (acc_done)        r_accSeen   <= 1'b1;
                    if (sys_finish)      r_sysSeen   <= 1'b1;
                    if (shift_out_valid) r_shiftSeen <= 1'b1;
                end
                default: ;
            endcase

            if (abort)
                r_tileIdx <= '0;
            else if (r_state == S_NEXT)
                r_tileIdx <= w_lastTile ? '0 : r_tileIdx + TILE_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_self_attention_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_self_attention_ctrl
// Brief    : Directed self-checking bench for self_attention_ctrl
//            (INNER_STEPS=4, NUM_TILES=2, TIMEOUT=16).
// Revision : 1.0  initial release
// ============================================================================
module tb_self_attention_ctrl;

    logic clk;
    logic rst;
    logic start;
    logic abort;
    logic in_data_valid;
    logic acc_done;
    logic sys_finish;
    logic shift_out_valid;
    logic b2r_ready;
    logic b2r_done;
    logic mm_rst_n;
    logic mm_en;
    logic mm_reset_acc;
    logic in_data_rd;
    logic b2r_start;
    logic [0:0] tile_idx;
    logic busy;
    logic done;
    logic err;

    int nTests = 0;
    int nFail  = 0;
    int nRd    = 0;
    int nEn    = 0;
    int nB2r   = 0;
    int nDone  = 0;

    self_attention_ctrl #(
        .INNER_STEPS(4),
        .NUM_TILES  (2),
        .TIMEOUT    (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .in_data_valid  (in_data_valid),
        .acc_done       (acc_done),
        .sys_finish     (sys_finish),
        .shift_out_valid(shift_out_valid),
        .b2r_ready      (b2r_ready),
        .b2r_done       (b2r_done),
        .mm_rst_n       (mm_rst_n),
        .mm_en          (mm_en),
        .mm_reset_acc   (mm_reset_acc),
        .in_data_rd     (in_data_rd),
        .b2r_start      (b2r_start),
        .tile_idx       (tile_idx),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe tallies sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (in_data_rd === 1'b1) nRd++;
            if (mm_en === 1'b1)      nEn++;
            if (b2r_start === 1'b1)  nB2r++;
            if (done === 1'b1)       nDone++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int rdBase;
        int enBase;
        int b2rBase;
        int doneBase;

        rst = 1'b1; start = 1'b0; abort = 1'b0; in_data_valid = 1'b0;
        acc_done = 1'b0; sys_finish = 1'b0; shift_out_valid = 1'b0;
        b2r_ready = 1'b0; b2r_done = 1'b0;

        // Reset state
        step(); step();
        in_data_valid = 1'b1;
        settle();
        check("rst_mm_rst_n", mm_rst_n, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_done", done, 0);
        check("rst_tile_idx", tile_idx, 0);
        check("rst_in_data_rd", in_data_rd, 0);
        check("rst_mm_en", mm_en, 0);
        in_data_valid = 1'b0;
        rst = 1'b0;
        step();
        settle();
        check("post_rst_mm_rst_n", mm_rst_n, 1);
        check("post_rst_busy", busy, 0);

        // Nominal two-tile pass
        b2rBase = nB2r; doneBase = nDone;
        b2r_ready = 1'b1; in_data_valid = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        settle();
        check("clr_reset_acc", mm_reset_acc, 1);
        check("clr_mm_rst_n", mm_rst_n, 0);
        check("clr_busy", busy, 1);
        check("clr_in_data_rd", in_data_rd, 0);
        for (int t = 0; t < 2; t++) begin
            rdBase = nRd;
            step(); step(); step(); step(); step();
            settle();
            check("nom_rd_per_tile", nRd - rdBase, 4);
            check("nom_wait_res_mm_en", mm_en, 1);
            check("nom_wait_res_rd", in_data_rd, 0);
            acc_done = 1'b1; sys_finish = 1'b1;
            step();
            acc_done = 1'b0; sys_finish = 1'b0;
            shift_out_valid = 1'b1;
            step();
            shift_out_valid = 1'b0;
            settle();
            check("nom_b2r_start", b2r_start, 1);
            check("nom_tile_idx", tile_idx, t);
            step(); step(); step();
            b2r_done = 1'b1;
            step();
            b2r_done = 1'b0;
            settle();
            check("nom_done_pulse", done, (t == 1) ? 1 : 0);
            step();
        end
        settle();
        check("nom_idle_busy", busy, 0);
        check("nom_idle_tile_idx", tile_idx, 0);
        check("nom_b2r_count", nB2r - b2rBase, 2);
        check("nom_done_count", nDone - doneBase, 1);

        // Toggling valid, out-of-order results, stalled B2R, abort in tile 1
        in_data_valid = 1'b0; b2r_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        rdBase = nRd; enBase = nEn;
        for (int k = 0; k < 7; k++) begin
            in_data_valid = (k % 2 == 0);
            if (k == 5) begin
                settle();
                check("tog_no_early_wait_res", mm_en, 0);
            end
            step();
        end
        in_data_valid = 1'b0; sys_finish = 1'b1;
        settle();
        check("tog_rd_count", nRd - rdBase, 4);
        check("tog_en_count", nEn - enBase, 4);
        check("tog_wait_res_mm_en", mm_en, 1);
        check("tog_wait_res_rd", in_data_rd, 0);
        step();
        sys_finish = 1'b0;
        step(); step();
        shift_out_valid = 1'b1;
        step();
        shift_out_valid = 1'b0;
        settle();
        check("ooo_still_wait_res", mm_en, 1);
        step();
        acc_done = 1'b1;
        step();
        acc_done = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            settle();
            check("stall_no_b2r_start", b2r_start, 0);
            check("stall_no_err", err, 0);
            step();
        end
        b2r_ready = 1'b1; b2r_done = 1'b1;
        settle();
        check("stall_b2r_start_on_ready", b2r_start, 1);
        check("stall_tile_idx", tile_idx, 0);
        step();
        b2r_ready = 1'b0; b2r_done = 1'b0;
        step();
        settle();
        check("early_b2r_done_ignored", mm_reset_acc, 0);
        check("early_b2r_done_busy", busy, 1);
        b2r_done = 1'b1;
        step();
        b2r_done = 1'b0;
        settle();
        check("next_tile0_no_done", done, 0);
        step();
        settle();
        check("tile1_idx", tile_idx, 1);
        check("tile1_clr", mm_reset_acc, 1);
        step();
        doneBase = nDone;
        in_data_valid = 1'b1; abort = 1'b1;
        step();
        abort = 1'b0; in_data_valid = 1'b0;
        settle();
        check("abort_busy", busy, 0);
        check("abort_tile_idx", tile_idx, 0);
        check("abort_err", err, 0);
        step(); step();
        check("abort_no_done", nDone - doneBase, 0);

        // Watchdog on missing acc_done
        in_data_valid = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step(); step(); step();
        for (int i = 1; i < 16; i++) step();
        settle();
        check("wdog_not_yet_err", err, 0);
        check("wdog_not_yet_busy", busy, 1);
        step();
        settle();
        check("wdog_err", err, 1);
        check("wdog_busy", busy, 0);
        check("wdog_mm_rst_n", mm_rst_n, 0);
        check("wdog_in_data_rd", in_data_rd, 0);
        check("wdog_mm_en", mm_en, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        settle();
        check("err_sticky", err, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        settle();
        check("err_abort_err", err, 0);
        check("err_abort_busy", busy, 0);
        check("err_abort_mm_rst_n", mm_rst_n, 1);

        // Reset in the middle of a pass
        doneBase = nDone;
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        settle();
        check("midrst_mm_rst_n", mm_rst_n, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rd", in_data_rd, 0);
        rst = 1'b0;
        in_data_valid = 1'b0;
        step();
        settle();
        check("midrst_after_mm_rst_n", mm_rst_n, 1);
        check("midrst_after_busy", busy, 0);
        check("midrst_after_tile_idx", tile_idx, 0);
        check("midrst_no_done", nDone - doneBase, 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/self_attention_ctrl.md
SELF_ATTENTION_CTRL -- requirements
Module: self_attention_ctrl

Interface
REQ-001 SHALL have parameter INNER_STEPS, default 4: accepted input beats per tile (Qn x Kn^T inner dimension).
REQ-002 SHALL have parameter NUM_TILES, default 8: output tiles per head pass.
REQ-003 SHALL have parameter TIMEOUT, default 1024: watchdog limit in cycles.
REQ-004 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports start  in  1  begin a pass; abort  in  1  cancel the pass.
REQ-007 SHALL have port in_data_valid  in  1  input buffers hold a beat for every matmul instance.
REQ-008 SHALL have ports acc_done  in  1  and sys_finish  in  1  from the matmul wrapper.
REQ-009 SHALL have port shift_out_valid  in  1  from the 4-bit right shifter.
REQ-010 SHALL have ports b2r_ready  in  1  and b2r_done  in  1  from the B2R converter.
REQ-011 SHALL have ports mm_rst_n  out  1  (active-low matmul reset), mm_en  out  1, mm_reset_acc  out  1.
REQ-012 SHALL have port in_data_rd  out  1  pop strobe to the input buffers.
REQ-013 SHALL have port b2r_start  out  1  one-cycle B2R launch.
REQ-014 SHALL have ports tile_idx  out  $clog2(NUM_TILES)  current tile, busy  out  1, done  out  1, err  out  1.

Function
REQ-015 SHALL implement states IDLE, CLR, FEED, WAIT_RES, WAIT_SHIFT, B2R_REQ, B2R_WAIT, NEXT, ERR.
REQ-016 IDLE: start=1 -> CLR next cycle; start SHALL be ignored in every other state.
REQ-017 CLR: exactly 1 cycle, mm_rst_n=0, mm_reset_acc=1, beat counter and sticky flags cleared; -> FEED.
REQ-018 FEED: mm_en=in_data_valid, in_data_rd=in_data_valid; beat counter increments per accepted beat; the cycle accepting beat INNER_STEPS -> WAIT_RES.
REQ-019 acc_seen, sys_seen, shift_seen SHALL be sticky flags set by acc_done, sys_finish, shift_out_valid in any of FEED..WAIT_SHIFT, cleared only in CLR, IDLE or reset.
REQ-020 WAIT_RES: mm_en=1; exit to WAIT_SHIFT once acc_seen and sys_seen are both set, in either order or simultaneously, including a same-cycle pulse.
REQ-021 WAIT_SHIFT: exit to B2R_REQ once shift_seen (or shift_out_valid this cycle) is set.
REQ-022 B2R_REQ: b2r_start=1 only in the cycle b2r_ready=1, then -> B2R_WAIT; hold in B2R_REQ while b2r_ready=0.
REQ-023 B2R_WAIT: b2r_done=1 -> NEXT; a b2r_done arriving in the b2r_start cycle SHALL be ignored.
REQ-024 NEXT (1 cycle): tile_idx<NUM_TILES-1 -> tile_idx+1, CLR; else done=1 for this single cycle, tile_idx->0, IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE and ERR.
REQ-026 Watchdog counts consecutive cycles in WAIT_RES, WAIT_SHIFT or B2R_WAIT, cleared on each state change; count reaching TIMEOUT -> ERR.
REQ-027 ERR: err=1 sticky, mm_rst_n=0, all strobes 0; exits only via rst or abort -> IDLE.
REQ-028 abort=1 in any state SHALL force IDLE next cycle, tile_idx->0, no done pulse, err cleared; abort has priority over every other transition.
REQ-029 mm_en, in_data_rd, mm_reset_acc, b2r_start, done SHALL be 0 outside the states granting them.

Reset
REQ-030 While rst=1: state IDLE, mm_rst_n=0, all other outputs 0, tile_idx=0, counters and flags 0.
REQ-031 First cycle after rst deasserts: mm_rst_n=1, IDLE; rst mid-pass SHALL discard the pass with no done.

Verification (INNER_STEPS=4, NUM_TILES=2, TIMEOUT=16)
REQ-032 start, in_data_valid held 1, acc_done+sys_finish same cycle, shift_out_valid next cycle, b2r_ready=1, b2r_done 3 cycles after b2r_start -> 4 in_data_rd per tile, two b2r_start pulses, tile_idx 0 then 1, one done pulse, back to IDLE.
REQ-033 in_data_valid toggling 1,0,1,0... -> exactly 4 in_data_rd and 4 mm_en cycles in FEED; WAIT_RES entered only after 4th beat.
REQ-034 sys_finish 5 cycles before acc_done, shift_out_valid while still in WAIT_RES -> no event lost, B2R_REQ reached without further stimulus.
REQ-035 acc_done never arrives -> err=1 exactly 16 cycles after WAIT_RES entry, busy=0, mm_rst_n=0; abort -> IDLE, err=0.
REQ-036 b2r_ready=0 for 6 cycles in B2R_REQ -> no b2r_start until ready, no timeout; abort in FEED of tile 1 -> IDLE next cycle, tile_idx=0, no done.
